// File: rtl/rv32_decode_issue.sv
// RV32 ID stage: decodes ALU-class instructions into an op-select, reads
// operands, interlocks read-after-write hazards through a pending-write
// scoreboard and issues registered operands to the EX-stage ALU.
module rv32_decode_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic [XLEN-1:0] reg_s1,
    output logic [XLEN-1:0] reg_s2,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] code_bus,
    output logic [3:0]      alu_opsel,
    output logic            enable,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic            illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic [3:0]      opsel_dec;
    logic            hazard;
    logic            fire;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    assign opcode      = if_instr[6:0];
    assign rd          = if_instr[11:7];
    assign funct3      = if_instr[14:12];
    assign rs1         = if_instr[19:15];
    assign rs2         = if_instr[24:20];
    assign funct7      = if_instr[31:25];
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    // Combinational decode: op-select, legality and which source registers are read.
    // Shifts are deliberately absent so they fall through as illegal.
    always_comb begin
        legal     = 1'b0;
        opsel_dec = 4'd0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  opsel_dec = 4'd0;
                        3'b111:  opsel_dec = 4'd2;
                        3'b110:  opsel_dec = 4'd3;
                        3'b100:  opsel_dec = 4'd4;
                        3'b010:  opsel_dec = 4'd5;
                        3'b011:  opsel_dec = 4'd6;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal     = 1'b1;
                    opsel_dec = 4'd1;
                end
            end
            OPC_OP_IMM: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  opsel_dec = 4'd7;
                    3'b111:  opsel_dec = 4'd9;
                    3'b110:  opsel_dec = 4'd10;
                    3'b100:  opsel_dec = 4'd11;
                    3'b010:  opsel_dec = 4'd12;
                    3'b011:  opsel_dec = 4'd13;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal     = 1'b1;
                opsel_dec = 4'd14;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                opsel_dec = 4'd15;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions read nothing, so they can never stall.
    assign use_rs1 = legal && (opcode == OPC_OP || opcode == OPC_OP_IMM);
    assign use_rs2 = legal && (opcode == OPC_OP);

    // Only the registered scoreboard is consulted: no same-cycle writeback bypass.
    assign hazard = if_valid &&
                    ((use_rs1 && rs1 != 5'd0 && sb[rs1]) ||
                     (use_rs2 && rs2 != 5'd0 && sb[rs2]));

    assign if_ready = !rst && !flush && !hazard;
    assign fire     = if_valid && if_ready;

    // Scoreboard next state: writeback clears, a new issue sets (set wins), x0 never pending.
    always_comb begin
        sb_next = sb;
        if (wb_valid && wb_rd != 5'd0) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (fire && legal && rd != 5'd0) begin
            sb_next[rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // Issue register: strobes pulse for one cycle, data holds unless a legal instruction fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= 1'b0;
            illegal   <= 1'b0;
            rd_we     <= 1'b0;
            rd_addr   <= 5'd0;
            alu_opsel <= 4'd0;
            reg_s1    <= '0;
            reg_s2    <= '0;
            pc        <= '0;
            code_bus  <= '0;
        end else begin
            enable  <= fire && legal;
            illegal <= fire && !legal;
            rd_we   <= fire && legal && (rd != 5'd0);
            if (fire && legal) begin
                rd_addr   <= rd;
                alu_opsel <= opsel_dec;
                reg_s1    <= rf_rs1_data;
                reg_s2    <= rf_rs2_data;
                pc        <= if_pc;
                code_bus  <= if_instr;
            end
        end
    end
endmodule

// File: tb/tb_rv32_decode_issue.sv
// Directed bench for rv32_decode_issue: every step pushes its expected issue
// record into a queue and pops it for comparison one edge later.
module tb_rv32_decode_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] reg_s1;
    logic [31:0] reg_s2;
    logic [31:0] pc;
    logic [31:0] code_bus;
    logic [3:0]  alu_opsel;
    logic        enable;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    rv32_decode_issue #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .reg_s1(reg_s1), .reg_s2(reg_s2), .pc(pc), .code_bus(code_bus),
        .alu_opsel(alu_opsel), .enable(enable), .rd_addr(rd_addr), .rd_we(rd_we),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ill;
        logic        we;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] pcv;
        logic [31:0] code;
    } issue_t;

    issue_t      expq[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] msb;
    issue_t      hold;

    localparam int ILL = 16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_enable"}, 32'(enable), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_rd_we"}, 32'(rd_we), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_opsel"}, 32'(alu_opsel), 32'd0);
        chk({tag, "_s1"}, reg_s1, 32'd0);
        chk({tag, "_s2"}, reg_s2, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_code"}, code_bus, 32'd0);
        chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    endtask

    // xop: hand-decoded op-select, or ILL for a non-ALU instruction.
    // want: required if_ready (0/1), or -1 to take it from the scoreboard model.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] ipc, input logic [31:0] d1, input logic [31:0] d2,
                        input logic fl, input logic wbv, input logic [4:0] wbrd,
                        input int xop, input int want);
        logic   u1, u2, haz, rdy, fire, leg;
        logic [4:0] r1, r2, rdn;
        issue_t rec, got;
        if_valid = v; if_instr = ins; if_pc = ipc; rf_rs1_data = d1; rf_rs2_data = d2;
        flush = fl; wb_valid = wbv; wb_rd = wbrd;
        #1;
        r1  = ins[19:15];
        r2  = ins[24:20];
        rdn = ins[11:7];
        leg = (xop != ILL);
        u1  = leg && (ins[6:0] == 7'h33 || ins[6:0] == 7'h13);
        u2  = leg && (ins[6:0] == 7'h33);
        haz = v && ((u1 && r1 != 0 && msb[r1]) || (u2 && r2 != 0 && msb[r2]));
        rdy = !fl && !haz;
        if (want >= 0) chk({tag, "_if_ready"}, 32'(if_ready), 32'(want));
        else           chk({tag, "_if_ready"}, 32'(if_ready), 32'(rdy));
        chk({tag, "_rs1_addr"}, 32'(rf_rs1_addr), 32'(r1));
        chk({tag, "_rs2_addr"}, 32'(rf_rs2_addr), 32'(r2));
        fire = v && rdy;
        rec  = hold;
        rec.en  = fire && leg;
        rec.ill = fire && !leg;
        rec.we  = fire && leg && (rdn != 0);
        if (fire && leg) begin
            rec.rd = rdn; rec.op = 4'(xop); rec.s1 = d1; rec.s2 = d2;
            rec.pcv = ipc; rec.code = ins;
        end
        hold = rec;
        expq.push_back(rec);
        if (wbv && wbrd != 0) msb[wbrd] = 1'b0;
        if (fire && leg && rdn != 0) msb[rdn] = 1'b1;
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_queue observed=empty expected=record", tag);
        end else begin
            got = expq.pop_front();
            chk({tag, "_enable"}, 32'(enable), 32'(got.en));
            chk({tag, "_illegal"}, 32'(illegal), 32'(got.ill));
            chk({tag, "_rd_we"}, 32'(rd_we), 32'(got.we));
            chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(got.rd));
            chk({tag, "_opsel"}, 32'(alu_opsel), 32'(got.op));
            chk({tag, "_s1"}, reg_s1, got.s1);
            chk({tag, "_s2"}, reg_s2, got.s2);
            chk({tag, "_pc"}, pc, got.pcv);
            chk({tag, "_code"}, code_bus, got.code);
        end
    endtask

    initial begin
        msb = '0;
        hold = '{default: '0};
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        rf_rs1_data = '0; rf_rs2_data = '0; wb_valid = 1'b0; wb_rd = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // add x3,x1,x2 with operands 5/7
        step("add", 1, 32'h002081B3, 32'h100, 5, 7, 0, 0, 0, 0, 1);
        // addi x5,x0,-1 then sub x6,x5,x5 stalls until after writeback of x5
        step("addi", 1, 32'hFFF00293, 32'h104, 0, 0, 0, 0, 0, 7, 1);
        step("sub_st0", 1, 32'h40528333, 32'h108, 9, 9, 0, 0, 0, 1, 0);
        step("sub_st1", 1, 32'h40528333, 32'h108, 9, 9, 0, 0, 0, 1, 0);
        step("sub_wb", 1, 32'h40528333, 32'h108, 9, 9, 0, 1, 5'd5, 1, 0);
        step("sub_go", 1, 32'h40528333, 32'h108, 9, 9, 0, 0, 0, 1, 1);
        // addi x1,x0,3 then lui x7 with x1 pending: no stall
        step("addi_x1", 1, 32'h00300093, 32'h10C, 0, 0, 0, 0, 0, 7, 1);
        step("lui", 1, 32'h123453B7, 32'h110, 32'hAA, 32'hBB, 0, 0, 0, 14, 1);
        // sll reads pending x3 but is illegal: never stalls, data holds
        step("sll", 1, 32'h003110B3, 32'h114, 1, 2, 0, 0, 0, ILL, 1);
        step("idle0", 0, 32'h003110B3, 32'h114, 1, 2, 0, 0, 0, ILL, -1);
        // addi x4,x0,1 then xori x4,x4,1 against a same-edge writeback of x4
        step("addi_x4", 1, 32'h00100213, 32'h118, 0, 0, 0, 0, 0, 7, 1);
        step("xori_wb", 1, 32'h00124213, 32'h11C, 1, 0, 0, 1, 5'd4, 11, 0);
        step("xori_go", 1, 32'h00124213, 32'h11C, 1, 0, 0, 0, 0, 11, 1);
        step("xori_again", 1, 32'h00124213, 32'h120, 1, 0, 0, 0, 0, 11, 0);
        // clear x1, then or x0,x1,x2: issues without a write, x0 stays free
        step("wb_x1", 0, 32'h0, 32'h0, 0, 0, 0, 1, 5'd1, ILL, -1);
        step("or_x0", 1, 32'h0020E033, 32'h124, 32'h0F, 32'hF0, 0, 0, 0, 3, 1);
        step("add_x8", 1, 32'h00000433, 32'h128, 0, 0, 0, 0, 0, 0, 1);
        // flush against auipc, then issue it
        step("auipc_fl", 1, 32'h00001497, 32'h12C, 0, 0, 1, 0, 0, 15, 0);
        step("auipc", 1, 32'h00001497, 32'h12C, 0, 0, 0, 0, 0, 15, 1);
        // add x10,x8,x8 stalls on x8; reset mid-stall clears everything at once
        step("add_x10_st", 1, 32'h00840533, 32'h130, 3, 3, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        msb  = '0;
        hold = '{default: '0};
        #3;
        rst = 1'b0;
        step("add_x10_go", 1, 32'h00840533, 32'h130, 3, 4, 0, 0, 0, 0, 1);
        step("idle1", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, ILL, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
